vga_mem_arbiter: RTL and testbench

- Shares one synchronous single-port video memory between the VGA hex display read path and a CPU-side requester.
- The display port has absolute priority: its address goes to memory in the same cycle, and its data returns with a fixed latency of MEM_DELAY cycles, matching the display's data_delay.
- CPU reads and writes are slotted into cycles where the display is idle, using a req/ack handshake.
- Sits between the hex display instance(s) and the frame/register memory.

---
 rtl/vga_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one synchronous single-port video memory between
// the hex display read path (absolute priority) and a CPU req/ack requester.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   disp_valid/addr     display read request (never stalled)
//   disp_data           display read data, MEM_DELAY cycles after disp_valid
//   cpu_req/we/addr/    CPU request, held until cpu_ack
//   cpu_wdata
//   cpu_ack, cpu_rdata  one-cycle completion pulse and held read data
//   mem_addr/we/wdata   memory command (combinational mux)
//   mem_rdata           memory read data, MEM_DELAY cycles after address
//   stall_cnt, stat_clr saturating CPU wait counter and its clear
module vga_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_DELAY   = 1,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   disp_valid,
    input  logic [ADDR_WIDTH-1:0]  disp_addr,
    output logic [DATA_WIDTH-1:0]  disp_data,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic                   cpu_ack,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [STALL_WIDTH-1:0] stall_cnt,
    input  logic                   stat_clr
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ISSUE,
        RDWAIT,
        ACK
    } state_t;

    state_t state, state_nxt;

    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // One bit per in-flight read slot; set when the slot belongs to the CPU.
    // The MSB marks the cycle in which the CPU's read data is on mem_rdata.
    logic [MEM_DELAY-1:0]  cpu_slot;

    logic latch;
    logic stall;
    logic issue_rd;
    logic capture;

    // Display wins every cycle it is valid; the CPU only drives the
    // memory from ISSUE in a cycle the display leaves free.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_valid) begin
            mem_addr = disp_addr;
        end else if (state == ISSUE) begin
            mem_addr  = req_addr;
            mem_we    = req_we & ~reset;
            mem_wdata = req_wdata;
        end
    end

    assign disp_data = mem_rdata;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        stall     = 1'b0;
        issue_rd  = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    latch     = 1'b1;
                    stall     = disp_valid;
                    state_nxt = disp_valid ? WAIT : ISSUE;
                end
            end
            WAIT: begin
                if (disp_valid) stall = 1'b1;
                else            state_nxt = ISSUE;
            end
            ISSUE: begin
                if (disp_valid) begin
                    stall     = 1'b1;
                    state_nxt = WAIT;
                end else if (req_we) begin
                    state_nxt = ACK;
                end else begin
                    issue_rd  = 1'b1;
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                if (cpu_slot[MEM_DELAY-1]) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cpu_slot  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state       <= state_nxt;
            cpu_ack     <= (state_nxt == ACK);
            cpu_slot[0] <= issue_rd;
            for (int i = 1; i < MEM_DELAY; i++) begin
                cpu_slot[i] <= cpu_slot[i-1];
            end
            if (latch) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (capture) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // Clear beats increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench for vga_mem_arbiter with
// MEM_DELAY=1 and MEM_DELAY=3 instances, each on its own memory model.
module tb_vga_mem_arbiter;

    typedef struct {
        int          due;
        logic [15:0] data;
        bit          rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic reset, init_en;

    logic        dv, req, we, clr, ack, m_we;
    logic [15:0] da, ca, cw, ddata, rdata;
    logic [15:0] m_addr, m_wdata, m_rdata, stall;

    logic        dv3, req3, we3, clr3, ack3, m_we3;
    logic [15:0] da3, ca3, cw3, ddata3, rdata3;
    logic [15:0] m_addr3, m_wdata3, m_rdata3, stall3;

    logic [15:0] sh1 [256];
    logic [15:0] sh3 [256];
    exp_t cq[$];
    exp_t dq[$];
    exp_t e;

    function automatic logic [15:0] iv(int i);
        return 16'(i * 16'h0111) ^ 16'hC3A5;
    endfunction

    vga_mem_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16),
        .MEM_DELAY(1), .STALL_WIDTH(16)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .disp_valid(dv), .disp_addr(da), .disp_data(ddata),
        .cpu_req(req), .cpu_we(we), .cpu_addr(ca),
        .cpu_wdata(cw), .cpu_ack(ack), .cpu_rdata(rdata),
        .mem_addr(m_addr), .mem_we(m_we), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .stall_cnt(stall), .stat_clr(clr)
    );

    vga_mem_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16),
        .MEM_DELAY(3), .STALL_WIDTH(16)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .disp_valid(dv3), .disp_addr(da3), .disp_data(ddata3),
        .cpu_req(req3), .cpu_we(we3), .cpu_addr(ca3),
        .cpu_wdata(cw3), .cpu_ack(ack3), .cpu_rdata(rdata3),
        .mem_addr(m_addr3), .mem_we(m_we3), .mem_wdata(m_wdata3),
        .mem_rdata(m_rdata3), .stall_cnt(stall3), .stat_clr(clr3)
    );

    // Memory models: one-cycle and three-cycle synchronous read.
    logic [15:0] mem1 [256];
    logic [15:0] p1;
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem1[i] <= iv(i);
        end else if (m_we) begin
            mem1[m_addr[7:0]] <= m_wdata;
        end
        p1 <= mem1[m_addr[7:0]];
    end
    assign m_rdata = p1;

    logic [15:0] mem3 [256];
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem3[i] <= iv(i);
        end else if (m_we3) begin
            mem3[m_addr3[7:0]] <= m_wdata3;
        end
        p3[0] <= mem3[m_addr3[7:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m_rdata3 = p3[2];

    task automatic test_reset();
        reset = 1'b1; init_en = 1'b1;
        req = 1'b1; we = 1'b1; ca = 16'h0005; cw = 16'h1111;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack got=%b exp=0", ack);
        end
        checks++;
        if (rdata !== 16'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        checks++;
        if (stall !== 16'h0) begin
            errors++; $display("FAIL reset_stall got=%h exp=0", stall);
        end
        checks++;
        if (m_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we got=%b exp=0", m_we);
        end
        checks++;
        if (ack3 !== 1'b0 || rdata3 !== 16'h0 || stall3 !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut3 got=%b/%h/%h exp=0/0/0",
                     ack3, rdata3, stall3);
        end
        @(negedge clk);
        reset = 1'b0; init_en = 1'b0; req = 1'b0; we = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (m_addr !== 16'h0 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_mux got=%h/%b exp=0/0", m_addr, m_we);
        end
    endtask

    task automatic test_write_read();
        int t0;
        bit got;
        cq.delete();
        @(negedge clk);
        req = 1'b1; we = 1'b1; ca = 16'h0012; cw = 16'hBEEF; dv = 1'b0;
        t0 = cyc;
        sh1[8'h12] = 16'hBEEF;
        cq.push_back('{t0 + 2, 16'hBEEF, 1'b0});
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (cyc == t0) begin
                checks++;
                if (m_we !== 1'b0) begin
                    errors++; $display("FAIL wr_latch_we got=%b exp=0", m_we);
                end
            end
            if (cyc == t0 + 1) begin
                checks++;
                if (m_we !== 1'b1 || m_addr !== 16'h0012) begin
                    errors++;
                    $display("FAIL wr_issue got=%b/%h exp=1/0012",
                             m_we, m_addr);
                end
                checks++;
                if (m_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL wr_wdata got=%h exp=beef", m_wdata);
                end
            end
            @(negedge clk);
            if (ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL wr_ack_cycle got=%0d exp=%0d", cyc, e.due);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL wr_timeout got=none exp=ack");
        end

        @(negedge clk);
        req = 1'b1; we = 1'b0; ca = 16'h0012; cw = 16'h0;
        t0 = cyc;
        cq.push_back('{t0 + 3, sh1[8'h12], 1'b1});
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL rd_ack_cycle got=%0d exp=%0d", cyc, e.due);
                end
                checks++;
                if (rdata !== e.data) begin
                    errors++;
                    $display("FAIL rd_data got=%h exp=%h", rdata, e.data);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rd_timeout got=none exp=ack");
        end
        @(negedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_hold got=%b/%h exp=0/beef", ack, rdata);
        end
    endtask

    task automatic test_disp_stall();
        bit got;
        cq.delete(); dq.delete();
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due || rdata !== e.data) begin
                    errors++;
                    $display("FAIL stall_rd got=%0d/%h exp=%0d/%h",
                             cyc, rdata, e.due, e.data);
                end
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                checks++;
                if (ddata !== e.data) begin
                    errors++;
                    $display("FAIL disp_data got=%h exp=%h", ddata, e.data);
                end
            end
            dv = (k < 10);
            da = 16'(k);
            if (k == 0) begin
                req = 1'b1; we = 1'b0; ca = 16'h0040;
                cq.push_back('{cyc + 13, sh1[8'h40], 1'b1});
            end
            #1;
            if (dv) begin
                checks++;
                if (m_addr !== da || m_we !== 1'b0) begin
                    errors++;
                    $display("FAIL disp_addr got=%h/%b exp=%h/0",
                             m_addr, m_we, da);
                end
                dq.push_back('{cyc + 1, sh1[da[7:0]], 1'b1});
            end
            if (k == 11) begin
                checks++;
                if (m_addr !== 16'h0040 || m_we !== 1'b0) begin
                    errors++;
                    $display("FAIL cpu_issue got=%h/%b exp=0040/0",
                             m_addr, m_we);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL stall_timeout got=none exp=ack");
        end
        checks++;
        if (stall !== 16'd10) begin
            errors++; $display("FAIL stall_cnt got=%0d exp=10", stall);
        end
    endtask

    task automatic test_slot_lost();
        bit got;
        cq.delete();
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL lost_ack got=%0d exp=%0d", cyc, e.due);
                end
            end
            if (k == 0) begin
                req = 1'b1; we = 1'b1; ca = 16'h0021; cw = 16'h1357;
                cq.push_back('{cyc + 7, 16'h1357, 1'b0});
                sh1[8'h21] = 16'h1357;
            end
            if (k == 1) begin
                ca = 16'h0099; cw = 16'hDEAD;
            end
            dv = (k >= 1 && k <= 4);
            da = 16'h0080 + 16'(k);
            #1;
            if (k < 6) begin
                checks++;
                if (m_we !== 1'b0) begin
                    errors++;
                    $display("FAIL lost_no_we k=%0d got=%b exp=0", k, m_we);
                end
            end
            if (k == 6) begin
                checks++;
                if (m_we !== 1'b1 || m_addr !== 16'h0021 ||
                    m_wdata !== 16'h1357) begin
                    errors++;
                    $display("FAIL lost_reissue got=%b/%h/%h exp=1/0021/1357",
                             m_we, m_addr, m_wdata);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL lost_timeout got=none exp=ack");
        end
        checks++;
        if (stall !== 16'd14) begin
            errors++; $display("FAIL lost_stall got=%0d exp=14", stall);
        end
    endtask

    task automatic test_stall_sat();
        bit got;
        cq.delete();
        got = 1'b0;
        for (int k = 0; k < 65560 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (stall !== 16'h0) begin
                    errors++; $display("FAIL clr_idle got=%h exp=0", stall);
                end
            end
            if (k >= 65536 && k <= 65538) begin
                checks++;
                if (stall !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL stall_sat k=%0d got=%h exp=ffff", k, stall);
                end
            end
            if (k == 65539) begin
                checks++;
                if (stall !== 16'h0) begin
                    errors++; $display("FAIL clr_prio got=%h exp=0", stall);
                end
            end
            if (ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due || rdata !== e.data) begin
                    errors++;
                    $display("FAIL sat_rd got=%0d/%h exp=%0d/%h",
                             cyc, rdata, e.due, e.data);
                end
            end
            clr = (k == 0 || k == 65538);
            dv = (k >= 1 && k <= 65538);
            da = 16'(k & 255);
            if (k == 1) begin
                req = 1'b1; we = 1'b0; ca = 16'h0033;
                cq.push_back('{cyc + 65541, sh1[8'h33], 1'b1});
            end
        end
        clr = 1'b0; dv = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL sat_timeout got=none exp=ack");
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        cq.delete();
        got = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 8) begin
                checks++;
                if (ack !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_no_ack k=%0d got=%b exp=0", k, ack);
                end
            end
            if (k == 3) begin
                checks++;
                if (rdata !== 16'h0) begin
                    errors++; $display("FAIL rst_rdata got=%h exp=0", rdata);
                end
            end
            if (k > 8 && ack === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req = 1'b0;
                checks++;
                if (cyc !== e.due || rdata !== e.data) begin
                    errors++;
                    $display("FAIL rst_new_rd got=%0d/%h exp=%0d/%h",
                             cyc, rdata, e.due, e.data);
                end
            end
            reset = (k == 2 || k == 3);
            dv = 1'b0;
            if (k == 0) begin
                req = 1'b1; we = 1'b0; ca = 16'h0021;
            end
            if (k == 2) req = 1'b0;
            if (k == 6) begin
                req = 1'b1; we = 1'b0; ca = 16'h0021;
                cq.push_back('{cyc + 3, sh1[8'h21], 1'b1});
            end
            #1;
            if (k == 4) begin
                checks++;
                if (m_addr !== 16'h0 || m_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_idle got=%h/%b exp=0/0", m_addr, m_we);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_timeout got=none exp=ack");
        end
    endtask

    task automatic test_md3();
        bit got;
        cq.delete(); dq.delete();
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack3 === 1'b1) begin
                e = cq.pop_front(); got = 1'b1; req3 = 1'b0;
                checks++;
                if (cyc !== e.due || rdata3 !== e.data) begin
                    errors++;
                    $display("FAIL md3_rd got=%0d/%h exp=%0d/%h",
                             cyc, rdata3, e.due, e.data);
                end
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                checks++;
                if (ddata3 !== e.data) begin
                    errors++;
                    $display("FAIL md3_disp got=%h exp=%h", ddata3, e.data);
                end
            end
            if (k == 0) begin
                req3 = 1'b1; we3 = 1'b0; ca3 = 16'h0055;
                cq.push_back('{cyc + 5, sh3[8'h55], 1'b1});
            end
            dv3 = (k >= 2 && k <= 4);
            da3 = 16'h0064 + 16'(k);
            #1;
            if (k == 1) begin
                checks++;
                if (m_addr3 !== 16'h0055 || m_we3 !== 1'b0) begin
                    errors++;
                    $display("FAIL md3_issue got=%h/%b exp=0055/0",
                             m_addr3, m_we3);
                end
            end
            if (dv3) begin
                checks++;
                if (m_addr3 !== da3) begin
                    errors++;
                    $display("FAIL md3_addr got=%h exp=%h", m_addr3, da3);
                end
                dq.push_back('{cyc + 3, sh3[da3[7:0]], 1'b1});
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL md3_timeout got=none exp=ack");
        end
        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL md3_disp_left got=%0d exp=0", dq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sh1[i] = iv(i);
            sh3[i] = iv(i);
        end
        reset = 1'b1; init_en = 1'b1;
        dv = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0;
        da = 16'h0; ca = 16'h0; cw = 16'h0;
        dv3 = 1'b0; req3 = 1'b0; we3 = 1'b0; clr3 = 1'b0;
        da3 = 16'h0; ca3 = 16'h0; cw3 = 16'h0;
        test_reset();
        test_write_read();
        test_disp_stall();
        test_slot_lost();
        test_stall_sat();
        test_reset_mid();
        test_md3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
